uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Transmit-side byte buffer placed directly upstream of the UART transmitter. Accepts bytes from the design at any rate, stores them in a small FIFO, and feeds them one at a time into the UART's write strobe / data input, respecting the UART's `tx_busy` flag. It replaces the free-running periodic write pulse as the UART's write source.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; power of two, at least 2.
- `ADDR_W`, 4: log2(DEPTH).
- `START_TIMEOUT`, 4: cycles after `uart_wr` within which `tx_busy` must rise before the byte is re-issued.

Ports:
- `clk`  in  1  system clock (50 MHz); all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-low; one clock; no other clocks.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  ADDR_W+1  bytes currently queued, 0..DEPTH.
- `overflow`  out  1  sticky: a push was attempted while full; cleared only by reset.
- `tx_busy`  in  1  UART transmitter busy flag.
- `uart_wr`  out  1  one-cycle write strobe to the UART.
- `uart_dat`  out  8  byte presented to the UART; stable from `uart_wr` until the next `uart_wr`.

## Operation
- FIFO: circular buffer, read/write pointers ADDR_W+1 bits wide. Full = MSBs differ and lower bits equal. Empty = pointers equal. Pointers wrap modulo 2·DEPTH.
- Push is accepted iff `wr_en` is high and `full` is low at that edge.
- Push while full: data dropped, pointers unchanged, `overflow` set. This applies even if a pop occurs in the same cycle.
- Simultaneous accepted push and pop: both take effect; `count` is unchanged.
- FSM states:
  - IDLE: if `!empty && !tx_busy`, pop the head byte into the `uart_dat` register and go to LOAD.
  - LOAD: `uart_wr`=1 for exactly this cycle. Clear the timeout counter and go to WAIT_START.
  - WAIT_START: if `tx_busy`, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches START_TIMEOUT, go to LOAD, re-issuing the same byte. No retry limit; no new pop.
  - WAIT_DONE: when `tx_busy`=0, go to IDLE.
- Reset values: state IDLE, pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0, `uart_wr` 0, `uart_dat` 8'h00.
- Reset mid-operation: queued bytes are discarded and the FSM returns to IDLE. A frame already in the UART is not aborted. The FSM waits in IDLE until `tx_busy` is 0 before popping.

## Timing
- All outputs are registered.
- Push at edge N updates `count`, `empty` and `full` at N+1.
- Idle path, empty FIFO and `tx_busy`=0: a push at edge N gives a pop and `uart_dat` valid at edge N+2, and `uart_wr` high during the cycle following edge N+2.
- Back-to-back transmission: `tx_busy` falls at edge M. Then WAIT_DONE→IDLE at M+1, pop at M+2, and `uart_wr` is high in the cycle after M+2. No byte is lost or duplicated.
- The pop happens once per byte, at the IDLE→LOAD edge only.
- `uart_wr` is never high in two consecutive cycles.
- `uart_wr` is never asserted while in WAIT_DONE.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding constants (IDLE, LOAD, WAIT_START, WAIT_DONE; 2 bits).
  - `UART_DATA_W` = 8.
- Sub-module `sync_fifo`: storage array, pointers, `full`, `empty`, `count`, overflow detect; parameterised by DEPTH, ADDR_W and width.
- `uart_tx_feeder` contains the FSM, the timeout counter and the `uart_dat` register.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `wr_en`=1 → `count`=0, `empty`=1, `uart_wr`=0, `uart_dat`=8'h00, `overflow`=0.
- Single byte: push 8'hA5 with the UART model raising `tx_busy` 1 cycle after `uart_wr` for 10 cycles → exactly one `uart_wr`, `uart_dat`=8'hA5, `empty`=1 afterwards.
- Burst: push 8'h01..8'h10 (16 bytes) on consecutive cycles → `full`=1 after the 16th push. UART receives 01..10 in order, one `uart_wr` per `tx_busy` low period.
- Overflow: fill 16 bytes with `tx_busy` held 1, then push 8'hFF → `overflow`=1, `count`=16, and 8'hFF is never transmitted.
- Timeout retry: model ignores the first `uart_wr` (no `tx_busy`) → `uart_wr` re-issued 5 cycles later with the same `uart_dat`, and `count` is decremented only once.
- Mid-frame reset: reset with 5 bytes queued and `tx_busy`=1 → `count`=0. No `uart_wr` until `tx_busy` falls and a new push arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: data width and feeder FSM encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned STATE_W     = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LOAD       = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers, registered status flags
// and a sticky overflow flag for pushes attempted while full.
module sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  output logic [WIDTH-1:0]  rd_data_c,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q;
  logic             full_q, empty_q;
  logic             overflow_q, overflow_d;
  logic             full_c, empty_c, push_c, pop_c;

  // Acceptance uses the live pointer comparison so back-to-back pushes never overrun.
  assign full_c  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign push_c  = wr_en_i && !full_c;
  assign pop_c   = rd_en_i && !empty_c;

  assign rd_data_c = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en_i && full_c) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= wr_ptr_q - rd_ptr_q;
      full_q     <= full_c;
      empty_q    <= empty_c;
      overflow_q <= overflow_d;
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue in front of the UART transmitter: pops one byte at a time and
// strobes it into the UART, re-issuing the strobe if tx_busy never rises.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic                   uart_wr,
  output logic [UART_DATA_W-1:0] uart_dat
);

  localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);

  state_t                   state_q, state_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     uart_wr_q, uart_wr_d;
  logic [UART_DATA_W-1:0]   uart_dat_q, uart_dat_d;
  logic                     pop_c;
  logic [UART_DATA_W-1:0]   fifo_rd_data;
  logic                     fifo_empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop_c),
    .rd_data_c  (fifo_rd_data),
    .full_o     (full),
    .empty_o    (fifo_empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  // The strobe is registered, so it is raised on every transition into LOAD.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    pop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop_c      = 1'b1;
          uart_dat_d = fifo_rd_data;
          uart_wr_d  = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tmo_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(START_TIMEOUT)) begin
            uart_wr_d = 1'b1;
            state_d   = ST_LOAD;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
    end
  end

  assign empty    = fifo_empty;
  assign uart_wr  = uart_wr_q;
  assign uart_dat = uart_dat_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple UART model on tx_busy.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH         = 16;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned START_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_busy;
  logic              uart_wr;
  logic [7:0]        uart_dat;

  bit   m_busy    = 1'b0;
  bit   hold_busy = 1'b0;
  bit   arm       = 1'b0;
  bit   prev_wr   = 1'b0;
  int   busy_left = 0;
  int   ignore_n  = 0;
  int   b2b       = 0;
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  logic [7:0] log_dat[$];
  int         log_cyc[$];
  int         log_cnt[$];

  assign tx_busy = m_busy | hold_busy;

  uart_tx_feeder #(
    .DEPTH         (DEPTH),
    .ADDR_W        (ADDR_W),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .uart_wr  (uart_wr),
    .uart_dat (uart_dat)
  );

  always #10 clk = ~clk;

  // UART model: busy for 10 cycles starting one cycle after an accepted strobe.
  always @(negedge clk) begin
    cyc++;
    if (arm) begin
      arm       = 1'b0;
      busy_left = 10;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (uart_wr === 1'b1) begin
      if (prev_wr) b2b++;
      log_dat.push_back(uart_dat);
      log_cyc.push_back(cyc);
      log_cnt.push_back(int'(count));
      if (ignore_n > 0) ignore_n--;
      else arm = 1'b1;
    end
    prev_wr = (uart_wr === 1'b1);
    m_busy  = (busy_left > 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_log(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (log_dat.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(log_dat.size() >= n), 32'd1);
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h77;

    // Reset held with a push request present
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_uart_wr", 32'(uart_wr), 32'd0);
    chk("rst_uart_dat", 32'(uart_dat), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);

    // Single byte through the idle path
    push(8'hA5);
    chk("sb_count_n", 32'(count), 32'd0);
    @(negedge clk);
    chk("sb_count_n1", 32'(count), 32'd1);
    chk("sb_wr_n1", 32'(uart_wr), 32'd0);
    @(negedge clk);
    chk("sb_wr_n2", 32'(uart_wr), 32'd1);
    chk("sb_dat_n2", 32'(uart_dat), 32'hA5);
    wait_log("sb_wait", 1, 40);
    repeat (25) @(negedge clk);
    chk("sb_nwr", 32'(log_dat.size()), 32'd1);
    chk("sb_logdat", 32'(log_dat[0]), 32'hA5);
    chk("sb_empty", 32'(empty), 32'd1);

    // Burst of 16 while UART busy, then overflow push
    log_dat.delete(); log_cyc.delete(); log_cnt.delete();
    hold_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("bu_full", 32'(full), 32'd1);
    chk("bu_count", 32'(count), 32'd16);
    chk("bu_ovf_pre", 32'(overflow), 32'd0);
    push(8'hFF);
    @(negedge clk);
    chk("ov_flag", 32'(overflow), 32'd1);
    chk("ov_count", 32'(count), 32'd16);
    chk("ov_full", 32'(full), 32'd1);
    hold_busy = 1'b0;
    wait_log("bu_wait", 16, 600);
    repeat (30) @(negedge clk);
    chk("bu_nwr", 32'(log_dat.size()), 32'd16);
    for (int i = 0; i < 16 && i < log_dat.size(); i++) begin
      chk($sformatf("bu_dat%0d", i), 32'(log_dat[i]), 32'(i + 1));
    end
    if (log_cyc.size() >= 2)
      chk("bu_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd13);
    chk("bu_empty", 32'(empty), 32'd1);
    chk("ov_sticky", 32'(overflow), 32'd1);

    // Timeout retry: first strobe ignored by the UART
    log_dat.delete(); log_cyc.delete(); log_cnt.delete();
    ignore_n = 1;
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_data = 8'h4D;
    @(negedge clk);
    wr_en   = 1'b0;
    wait_log("to_wait", 3, 100);
    repeat (25) @(negedge clk);
    chk("to_nwr", 32'(log_dat.size()), 32'd3);
    if (log_dat.size() >= 3) begin
      chk("to_dat0", 32'(log_dat[0]), 32'h3C);
      chk("to_dat1", 32'(log_dat[1]), 32'h3C);
      chk("to_dat2", 32'(log_dat[2]), 32'h4D);
      chk("to_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd5);
      chk("to_cnt0", 32'(log_cnt[0]), 32'd2);
      chk("to_cnt1", 32'(log_cnt[1]), 32'd1);
    end
    chk("to_count_end", 32'(count), 32'd0);

    // Reset with bytes queued and a frame in flight
    log_dat.delete(); log_cyc.delete(); log_cnt.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h50 + i);
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("mr_count_pre", 32'(count), 32'd5);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_ovf_clr", 32'(overflow), 32'd0);
    repeat (10) @(negedge clk);
    hold_busy = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_nowr", 32'(log_dat.size()), 32'd0);
    push(8'h5A);
    wait_log("mr_wait", 1, 40);
    repeat (20) @(negedge clk);
    chk("mr_nwr", 32'(log_dat.size()), 32'd1);
    if (log_dat.size() >= 1)
      chk("mr_dat", 32'(log_dat[0]), 32'h5A);

    chk("wr_b2b", 32'(b2b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
